// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequences RV32M multiplies through a shared multicycle 32x32 unsigned array.
// Optional one-entry result cache is compiled in when MUL_CACHE_EN is defined.
module mul_seq_ctrl #(
    parameter int N      = 32,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    input  logic         kill,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [N-1:0] mul_a,
    output logic [N-1:0] mul_b,
    input  logic [N-1:0] mul_hi,
    input  logic [N-1:0] mul_lo,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] x);
        return -x;
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] x);
        return -x;
    endfunction

    logic [1:0]     state_r;
    logic [3:0]     cnt_r;
    logic [1:0]     op_r;
    logic           neg_r;
    logic [2*N-1:0] prod_r;
    logic [N-1:0]   mul_a_r;
    logic [N-1:0]   mul_b_r;
    logic [N-1:0]   rsp_data_r;
    logic           rsp_valid_r;

    logic           sa_mode_s;
    logic           sb_mode_s;
    logic           sa_s;
    logic           sb_s;
    logic           accept_s;
    logic [2*N-1:0] fix_s;
    logic [N-1:0]   fix_word_s;
    logic           hit_s;
    logic [N-1:0]   hit_word_s;

    // The array is unsigned: signed operands are fed as magnitudes and the sign is restored in FIX.
    assign sa_mode_s  = (req_op == OP_MULH) || (req_op == OP_MULHSU);
    assign sb_mode_s  = (req_op == OP_MULH);
    assign sa_s       = req_a[N-1] & sa_mode_s;
    assign sb_s       = req_b[N-1] & sb_mode_s;
    assign accept_s   = (state_r == ST_IDLE) && req_valid && !kill;
    assign fix_s      = neg_r ? neg_2n(prod_r) : prod_r;
    assign fix_word_s = (op_r == OP_MUL) ? fix_s[N-1:0] : fix_s[2*N-1:N];

    assign req_ready  = (state_r == ST_IDLE) && !kill;
    assign busy       = (state_r != ST_IDLE);
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign mul_a      = mul_a_r;
    assign mul_b      = mul_b_r;

`ifdef MUL_CACHE_EN
    logic           cache_vld_r;
    logic [N-1:0]   cache_a_r;
    logic [N-1:0]   cache_b_r;
    logic           cache_sam_r;
    logic           cache_sbm_r;
    logic [2*N-1:0] cache_res_r;

    // The low word is signedness-independent, so MUL ignores the mode bits of the tag.
    assign hit_s = cache_vld_r && (req_a == cache_a_r) && (req_b == cache_b_r) &&
                   ((req_op == OP_MUL) || ((sa_mode_s == cache_sam_r) && (sb_mode_s == cache_sbm_r)));
    assign hit_word_s = (req_op == OP_MUL) ? cache_res_r[N-1:0] : cache_res_r[2*N-1:N];

    // Tag is captured on a missed acceptance and marked valid once the corrected result exists.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cache_vld_r <= 1'b0;
            cache_a_r   <= {N{1'b0}};
            cache_b_r   <= {N{1'b0}};
            cache_sam_r <= 1'b0;
            cache_sbm_r <= 1'b0;
            cache_res_r <= {(2*N){1'b0}};
        end else if (kill) begin
            cache_vld_r <= 1'b0;
        end else if (accept_s && !hit_s) begin
            cache_vld_r <= 1'b0;
            cache_a_r   <= req_a;
            cache_b_r   <= req_b;
            cache_sam_r <= sa_mode_s;
            cache_sbm_r <= sb_mode_s;
        end else if (state_r == ST_FIX) begin
            cache_vld_r <= 1'b1;
            cache_res_r <= fix_s;
        end
    end
`else
    assign hit_s      = 1'b0;
    assign hit_word_s = {N{1'b0}};
`endif

    // Main sequencer: accept, hold operands for SETTLE cycles, capture, correct sign, respond.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            op_r        <= 2'b00;
            neg_r       <= 1'b0;
            prod_r      <= {(2*N){1'b0}};
            mul_a_r     <= {N{1'b0}};
            mul_b_r     <= {N{1'b0}};
            rsp_data_r  <= {N{1'b0}};
            rsp_valid_r <= 1'b0;
        end else if (kill) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_r <= req_op;
                        if (hit_s) begin
                            rsp_data_r <= hit_word_s;
                            state_r    <= ST_RESP;
                        end else begin
                            mul_a_r <= sa_s ? neg_n(req_a) : req_a;
                            mul_b_r <= sb_s ? neg_n(req_b) : req_b;
                            neg_r   <= sa_s ^ sb_s;
                            cnt_r   <= SETTLE_CNT;
                            state_r <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        prod_r  <= {mul_hi, mul_lo};
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    rsp_data_r  <= fix_word_s;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    // A cache hit enters RESP with valid still low; raise it one cycle later.
                    if (!rsp_valid_r) begin
                        rsp_valid_r <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
